// File: rtl/mux8_pkg.sv
// Shared definitions for the 8:1 mux select sequencer.
// Holds the FSM state encoding and the datapath widths.
package mux8_pkg;

  localparam int unsigned DATA_W = 8;
  localparam int unsigned SEL_W  = 3;
  localparam int unsigned CNT_W  = 8;

  localparam logic [SEL_W-1:0] SEL_LAST = 3'd7;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SHIFT  = 2'd1,
    ST_PARITY = 2'd2
  } state_t;

endpackage

// File: rtl/bit_tick_gen.sv
// Bit-period divider: counts enabled cycles and pulses tick on the last
// cycle of each DIV-cycle bit period. clr restarts the period.
module bit_tick_gen
  import mux8_pkg::*;
#(
  parameter int unsigned DIV = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV - 1);

  logic [CNT_W-1:0] div_cnt;

  // Period counter: wraps to zero on the last cycle of each bit.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      div_cnt <= '0;
    end else if (en) begin
      if (div_cnt == CNT_LAST) begin
        div_cnt <= '0;
      end else begin
        div_cnt <= div_cnt + 1'b1;
      end
    end
  end

  // Tick only while counting, so an idle sequencer never sees one.
  always_comb begin
    tick = en && (div_cnt == CNT_LAST);
  end

endmodule

// File: rtl/mux8_sel_sequencer.sv
// Upstream driver for the 8:1 mux datapath: accepts a byte over valid/ready,
// then steps the mux select 0..7 presenting one bit per DIV cycles on sout,
// LSB first. Define PARITY_EN to append an even-parity bit after bit 7.
module mux8_sel_sequencer
  import mux8_pkg::*;
#(
  parameter int unsigned DIV = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] din,
  input  logic              din_valid,
  output logic              din_ready,
  output logic [SEL_W-1:0]  sel,
  output logic              sout,
  output logic              sout_valid,
  output logic              sout_last,
  output logic              busy
);

  state_t            state;
  state_t            state_nxt;
  logic [DATA_W-1:0] word_q;
  logic              tick;
  logic              last_bit;
  logic              end_frame;
  logic              accept;
  logic              counting;

  assign counting = (state != ST_IDLE);

  bit_tick_gen #(
    .DIV (DIV)
  ) u_tick (
    .clk  (clk),
    .rst  (rst),
    .en   (counting),
    .clr  (accept),
    .tick (tick)
  );

  // Handshake and frame-boundary decode; depends only on registered state.
  always_comb begin
`ifdef PARITY_EN
    last_bit = (state == ST_PARITY);
`else
    last_bit = (state == ST_SHIFT) && (sel == SEL_LAST);
`endif
    end_frame = tick && last_bit;
    din_ready = (state == ST_IDLE) || end_frame;
    accept    = din_valid && din_ready;
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic; end of frame restarts directly when a word is waiting.
  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE: begin
        if (accept) begin
          state_nxt = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (tick && (sel == SEL_LAST)) begin
`ifdef PARITY_EN
          state_nxt = ST_PARITY;
`else
          state_nxt = accept ? ST_SHIFT : ST_IDLE;
`endif
        end
      end
`ifdef PARITY_EN
      ST_PARITY: begin
        if (tick) begin
          state_nxt = accept ? ST_SHIFT : ST_IDLE;
        end
      end
`endif
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Held word: captured on every accepted handshake.
  always_ff @(posedge clk) begin
    if (rst) begin
      word_q <= '0;
    end else if (accept) begin
      word_q <= din;
    end
  end

  // Mux select: advances on each bit tick, parks at 7 for parity, and only
  // returns to 0 through a frame restart or the return to idle.
  always_ff @(posedge clk) begin
    if (rst) begin
      sel <= '0;
    end else if (accept || end_frame) begin
      sel <= '0;
    end else if ((state == ST_SHIFT) && tick && (sel != SEL_LAST)) begin
      sel <= sel + 1'b1;
    end
  end

  // Serial outputs decoded from registered state.
  always_comb begin
    busy       = (state != ST_IDLE);
    sout_valid = busy;
    sout_last  = last_bit;
    sout       = 1'b0;
    unique case (state)
      ST_SHIFT:  sout = word_q[sel];
`ifdef PARITY_EN
      ST_PARITY: sout = ^word_q;
`endif
      default:   sout = 1'b0;
    endcase
  end

endmodule
